// File: rtl/prefix_adder_pkg.sv
// Shared constants and FSM encoding for the chunked prefix subtractor.
package prefix_adder_pkg;

  localparam int DATA_W      = 64;
  localparam int CHUNK_W_DEF = 16;

  function automatic int num_chunks(input int chunk_w);
    return DATA_W / chunk_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prefix_sub_slice.sv
// Combinational W-bit a - b - bin using a Kogge-Stone generate/propagate prefix tree.
module prefix_sub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int LEVELS = $clog2(W);

  logic [W-1:0] p_s;
  logic [W-1:0] g_s;
  logic [W-1:0] pp_s;
  logic [W-1:0] gg_s;
  logic [W-1:0] c_s;

  // a - b - bin == a + ~b + ~bin; the carry-in is folded into bit 0's generate
  always_comb begin
    p_s     = a ^ ~b;
    g_s     = a & ~b;
    pp_s    = p_s;
    gg_s    = g_s;
    gg_s[0] = g_s[0] | (p_s[0] & ~bin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = W - 1; i >= (1 << l); i--) begin
        gg_s[i] = gg_s[i] | (pp_s[i] & gg_s[i - (1 << l)]);
        pp_s[i] = pp_s[i] & pp_s[i - (1 << l)];
      end
    end
    c_s  = {gg_s[W-2:0], ~bin};
    diff = p_s ^ c_s;
    bout = ~gg_s[W-1];
  end

endmodule

// File: rtl/prefix_subtractor_seq.sv
// Sequential 64-bit subtractor: one CHUNK_W slice per cycle, borrow rippled between cycles.
module prefix_subtractor_seq
  import prefix_adder_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] sayi1,
  input  logic [63:0] sayi2,
  output logic        ready,
  output logic        done,
  output logic [63:0] fark,
  output logic        borrow
);

  localparam int NUM_CHUNKS = num_chunks(CHUNK_W);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             state_r;
  state_t             state_nx_s;
  logic               ready_r;
  logic               ready_nx_s;
  logic               done_r;
  logic               done_nx_s;
  logic [63:0]        a_r;
  logic [63:0]        b_r;
  logic [63:0]        fark_r;
  logic               borrow_r;
  logic [IDX_W-1:0]   idx_r;
  logic               bin_r;
  logic [CHUNK_W-1:0] a_slice_s;
  logic [CHUNK_W-1:0] b_slice_s;
  logic [CHUNK_W-1:0] diff_s;
  logic               bout_s;

  assign a_slice_s = a_r[idx_r*CHUNK_W +: CHUNK_W];
  assign b_slice_s = b_r[idx_r*CHUNK_W +: CHUNK_W];

  prefix_sub_slice #(.W(CHUNK_W)) u_slice (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .bin  (bin_r),
    .diff (diff_s),
    .bout (bout_s)
  );

  // Next-state decode; ready/done are derived from the next state so they register cleanly
  always_comb begin
    state_nx_s = state_r;
    ready_nx_s = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = CALC;
        else       state_nx_s = IDLE;
      end
      CALC: begin
        if (idx_r == LAST_IDX) state_nx_s = DONE;
        else                   state_nx_s = CALC;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
    if (state_nx_s == IDLE) ready_nx_s = 1'b1;
    else                    ready_nx_s = 1'b0;
    if (state_nx_s == DONE) done_nx_s = 1'b1;
    else                    done_nx_s = 1'b0;
  end

  // State and handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= ready_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Operand capture and per-slice result/borrow accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      fark_r   <= 64'd0;
      borrow_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      bin_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= sayi1;
            b_r   <= sayi2;
            idx_r <= {IDX_W{1'b0}};
            bin_r <= 1'b0;
          end
        end
        CALC: begin
          fark_r[idx_r*CHUNK_W +: CHUNK_W] <= diff_s;
          bin_r <= bout_s;
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) borrow_r <= bout_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign fark   = fark_r;
  assign borrow = borrow_r;

endmodule

// File: tb/tb_prefix_subtractor_seq.sv
// Randomised self-checking bench for prefix_subtractor_seq against a cycle-count/65-bit arithmetic model.
module tb_prefix_subtractor_seq;

  localparam int CW = 16;
  localparam int N  = 64 / CW;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] sayi1;
  logic [63:0] sayi2;
  logic        ready;
  logic        done;
  logic [63:0] fark;
  logic        borrow;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = idle, 1..N = slices in flight, N+1 = done cycle
  int          m_phase = 0;
  logic [63:0] m_a     = 64'd0;
  logic [63:0] m_b     = 64'd0;
  logic [63:0] m_fark  = 64'd0;
  logic        m_bor   = 1'b0;
  bit          m_valid = 1'b1;

  prefix_subtractor_seq #(.CHUNK_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sayi1  (sayi1),
    .sayi2  (sayi2),
    .ready  (ready),
    .done   (done),
    .fark   (fark),
    .borrow (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_fark  <= 64'd0;
      m_bor   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     <= sayi1;
        m_b     <= sayi2;
        m_phase <= 1;
        m_valid <= 1'b0;
      end
    end else if (m_phase == N) begin
      {m_bor, m_fark} <= {1'b0, m_a} - {1'b0, m_b};
      m_valid <= 1'b1;
      m_phase <= N + 1;
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 64'(ready), 64'(m_phase == 0));
      chk("done", 64'(done), 64'(m_phase == N + 1));
      if (m_valid) begin
        chk("fark", fark, m_fark);
        chk("borrow", 64'(borrow), 64'(m_bor));
      end
    end
  end

  // Called just after the accepting edge; returns at the negedge where done is high
  task automatic wait_done(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int k = 0; k < 4 * N + 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done pulse expected one within %0d edges", 4 * N + 8);
    end
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b, input bit lit,
                    input logic [63:0] ef, input logic eb, input string name);
    int lat;
    bit ok;
    sayi1 = a;
    sayi2 = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sayi1 = {$urandom(), $urandom()};
    sayi2 = {$urandom(), $urandom()};
    wait_done(lat, ok);
    if (ok) begin
      chk({name, "_latency"}, 64'(lat), 64'(N + 1));
      if (lit) begin
        chk({name, "_fark"}, fark, ef);
        chk({name, "_borrow"}, 64'(borrow), 64'(eb));
        chk({name, "_model"}, m_fark, ef);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit ok;
    logic [63:0] ra;
    logic [63:0] rb;
    rst_n = 1'b1;
    start = 1'b0;
    sayi1 = 64'd0;
    sayi2 = 64'd0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fark", fark, 64'd0);
    chk("rst_borrow", 64'(borrow), 64'd0);
    rst_n = 1'b1;

    op(64'd5, 64'd3, 1'b1, 64'd2, 1'b0, "sub_5_3");
    op(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "sub_0_1");
    op(64'h0001_0000_0000_0000, 64'd1, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, "cross");

    // start held high through CALC/DONE with new operands: ignored, then accepted in first IDLE
    sayi1 = 64'd100;
    sayi2 = 64'd58;
    start = 1'b1;
    @(posedge clk); #1;
    sayi1 = 64'd7;
    sayi2 = 64'd9;
    wait_done(lat, ok);
    if (ok) begin
      chk("ignore_latency", 64'(lat), 64'(N + 1));
      chk("ignore_fark", fark, 64'd42);
      chk("ignore_borrow", 64'(borrow), 64'd0);
    end
    @(posedge clk); #1;
    chk("b2b_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, ok);
    if (ok) begin
      chk("b2b_latency", 64'(lat), 64'(N + 1));
      chk("b2b_fark", fark, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("b2b_borrow", 64'(borrow), 64'd1);
    end
    @(posedge clk); #1;

    // reset asserted mid-operation while slice 2 is being computed
    sayi1 = 64'hFFFF_0000_FFFF_0000;
    sayi2 = 64'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_fark", fark, 64'd0);
    chk("abort_borrow", 64'(borrow), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
       64'h0246_8ACF_1357_9BCF, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 64'd0;
        2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        3: rb = ra + 64'd1;
        default: begin
        end
      endcase
      op(ra, rb, 1'b0, 64'd0, 1'b0, "rand");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
